sdpktfifo: RTL and testbench

- Synchronous packet FIFO for the SD-SPI data path; successor to the plain synchronous data FIFO.
- Adds packet commit/abort on the write side, so a block that fails CRC is rolled back and never reaches the reader.
- Adds a programmable almost-full threshold, sticky overflow flagging with automatic drop of corrupted packets, and a selectable registered first-word-fall-through read port.
- Sits between the SD receive engine (writer) and the bus/DMA drain (reader).

---
 rtl/sdpktfifo_oreg.sv | 31 +++
 rtl/sdpktfifo.sv | 134 +++++++++++++
 tb/tb_sdpktfifo.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sdpktfifo_oreg.sv
// Registered first-word-fall-through output stage for sdpktfifo.
// Holds the head word in a register; refills from memory when empty or
// when the current head is consumed, and keeps its last value while empty.
module sdpktfifo_oreg #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [BW-1:0] mem_data,   // memory word at the next read address
  input  logic          avail,      // a committed word exists at that address
  input  logic          rd_accept,  // current head is being consumed
  output logic [BW-1:0] data,
  output logic          empty
);

  // Output register and its empty flag; loads only when a valid word is there
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data  <= {BW{1'b0}};
      empty <= 1'b1;
    end else begin
      empty <= !avail;
      if ((empty || rd_accept) && avail) begin
        data <= mem_data;
      end else begin
        data <= data;
      end
    end
  end

endmodule

// File: rtl/sdpktfifo.sv
// Synchronous packet FIFO: writes become visible to the reader only after
// commit; abort (or a commit of a packet that overflowed) rolls the write
// pointer back to the last committed word.
module sdpktfifo #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter int OPT_ASYNC_READ = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_commit,
  input  logic              i_abort,
  input  logic [LGFLEN:0]   i_afull_level,
  input  logic              i_clr_err,
  output logic              o_full,
  output logic [LGFLEN:0]   o_wfill,
  output logic              o_afull,
  output logic              o_overflow,
  output logic              o_drop,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill
);

  localparam logic [LGFLEN:0] FLEN = {1'b1, {LGFLEN{1'b0}}};

  logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN:0] wr_addr, cmt_addr, rd_addr;
  logic            pkt_err;

  logic            wr_accept, ovf_now, rd_accept, has_uncmt, drop_now, pkt_err_next;
  logic [LGFLEN:0] wr_adv, wr_next, cmt_next, rd_next, wfill_next, fill_next;

  // Next-state pointer arithmetic for write, commit/abort and read
  always_comb begin
    wr_accept  = i_wr && !o_full;
    ovf_now    = i_wr && o_full;
    rd_accept  = i_rd && !o_empty;
    wr_adv     = wr_addr + {{LGFLEN{1'b0}}, wr_accept};
    has_uncmt  = (wr_adv != cmt_addr);
    wr_next    = wr_adv;
    cmt_next   = cmt_addr;
    drop_now   = 1'b0;
    pkt_err_next = pkt_err || ovf_now;
    if (i_abort) begin
      wr_next      = cmt_addr;
      pkt_err_next = 1'b0;
    end else if (i_commit) begin
      pkt_err_next = 1'b0;
      // A packet that lost a word (even this cycle) is rolled back
      if (pkt_err || ovf_now) begin
        wr_next  = cmt_addr;
        drop_now = has_uncmt;
      end else begin
        cmt_next = wr_adv;
      end
    end else begin
      wr_next = wr_adv;
    end
    rd_next    = rd_addr + {{LGFLEN{1'b0}}, rd_accept};
    wfill_next = wr_next - rd_next;
    fill_next  = cmt_next - rd_next;
  end

  // Storage array; aborted same-cycle writes are not stored
  always_ff @(posedge i_clk) begin
    if (wr_accept && !i_abort) begin
      mem[wr_addr[LGFLEN-1:0]] <= i_data;
    end
  end

  // Pointers, packet error state and all registered flags
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_addr    <= {(LGFLEN+1){1'b0}};
      cmt_addr   <= {(LGFLEN+1){1'b0}};
      rd_addr    <= {(LGFLEN+1){1'b0}};
      pkt_err    <= 1'b0;
      o_full     <= 1'b0;
      o_wfill    <= {(LGFLEN+1){1'b0}};
      o_fill     <= {(LGFLEN+1){1'b0}};
      o_afull    <= (i_afull_level == {(LGFLEN+1){1'b0}});
      o_overflow <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      wr_addr    <= wr_next;
      cmt_addr   <= cmt_next;
      rd_addr    <= rd_next;
      pkt_err    <= pkt_err_next;
      o_full     <= (wfill_next == FLEN);
      o_wfill    <= wfill_next;
      o_fill     <= fill_next;
      o_afull    <= (wfill_next >= i_afull_level);
      o_overflow <= ovf_now || (o_overflow && !i_clr_err);
      o_drop     <= drop_now;
    end
  end

  generate
    if (OPT_ASYNC_READ != 0) begin : g_async
      logic empty_q;

      // Empty flag tracks the committed pointer directly
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          empty_q <= 1'b1;
        end else begin
          empty_q <= (cmt_next == rd_next);
        end
      end

      assign o_empty = empty_q;
      assign o_data  = mem[rd_addr[LGFLEN-1:0]];
    end else begin : g_reg
      logic avail;
      // Uses the pre-edge committed pointer: the word is already in memory
      assign avail = (cmt_addr != rd_next);

      sdpktfifo_oreg #(.BW(BW)) u_oreg (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .mem_data  (mem[rd_next[LGFLEN-1:0]]),
        .avail     (avail),
        .rd_accept (rd_accept),
        .data      (o_data),
        .empty     (o_empty)
      );
    end
  endgenerate

endmodule

// File: tb/tb_sdpktfifo.sv
// Self-checking bench for sdpktfifo: one instance per read-port option,
// shared write-side stimulus, per-instance read scoreboards.
module tb_sdpktfifo;

  logic       clk = 1'b0;
  logic       reset_n, wr, commit, abort, clr_err, rd_a, rd_r;
  logic [7:0] data;
  logic [4:0] afull_level;

  logic       a_full, a_afull, a_ovf, a_drop, a_empty;
  logic [4:0] a_wfill, a_fill;
  logic [7:0] a_data;
  logic       r_full, r_afull, r_ovf, r_drop, r_empty;
  logic [4:0] r_wfill, r_fill;
  logic [7:0] r_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qr[$];
  logic [7:0] pend[$];
  logic       m_err;

  always #5 clk = ~clk;

  sdpktfifo #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(1)) u_async (
    .i_clk(clk), .i_reset_n(reset_n), .i_wr(wr), .i_data(data),
    .i_commit(commit), .i_abort(abort), .i_afull_level(afull_level),
    .i_clr_err(clr_err), .o_full(a_full), .o_wfill(a_wfill), .o_afull(a_afull),
    .o_overflow(a_ovf), .o_drop(a_drop), .i_rd(rd_a), .o_data(a_data),
    .o_empty(a_empty), .o_fill(a_fill));

  sdpktfifo #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(0)) u_reg (
    .i_clk(clk), .i_reset_n(reset_n), .i_wr(wr), .i_data(data),
    .i_commit(commit), .i_abort(abort), .i_afull_level(afull_level),
    .i_clr_err(clr_err), .o_full(r_full), .o_wfill(r_wfill), .o_afull(r_afull),
    .o_overflow(r_ovf), .o_drop(r_drop), .i_rd(rd_r), .o_data(r_data),
    .o_empty(r_empty), .o_fill(r_fill));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both instances compared against the same expected value
  task automatic chk2(input string tag, input logic [31:0] oa, input logic [31:0] orr,
                      input logic [31:0] exp);
    chk({"async_", tag}, oa, exp);
    chk({"reg_", tag}, orr, exp);
  endtask

  // One clock: drive write side, read whatever head is visible, update model
  task automatic cycle(input logic w, input logic [7:0] d, input logic c,
                       input logic ab, input logic r);
    logic full_now;
    wr = w; data = d; commit = c; abort = ab;
    rd_a = r && !a_empty;
    rd_r = r && !r_empty;
    if (rd_a) begin
      if (qa.size() == 0) chk("async_unexpected_read", 32'd1, 32'd0);
      else chk("async_data", {24'd0, a_data}, {24'd0, qa.pop_front()});
    end
    if (rd_r) begin
      if (qr.size() == 0) chk("reg_unexpected_read", 32'd1, 32'd0);
      else chk("reg_data", {24'd0, r_data}, {24'd0, qr.pop_front()});
    end
    full_now = (qa.size() + pend.size() >= 16);
    if (w && full_now) m_err = 1'b1;
    else if (w && !ab) pend.push_back(d);
    if (ab) begin
      pend.delete(); m_err = 1'b0;
    end else if (c) begin
      if (!m_err) begin
        foreach (pend[i]) begin qa.push_back(pend[i]); qr.push_back(pend[i]); end
      end
      pend.delete(); m_err = 1'b0;
    end
    @(posedge clk); #1;
    wr = 1'b0; commit = 1'b0; abort = 1'b0; rd_a = 1'b0; rd_r = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qr.size() != 0 || !a_empty || !r_empty) && n < 60) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_left_async", qa.size(), 32'd0);
    chk("drain_left_reg", qr.size(), 32'd0);
    chk2("empty_after_drain", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b0; commit = 1'b0; abort = 1'b0; clr_err = 1'b0;
    rd_a = 1'b0; rd_r = 1'b0; data = 8'h00; afull_level = 5'd0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk2("rst_full", {31'd0, a_full}, {31'd0, r_full}, 32'd0);
    chk2("rst_empty", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
    chk2("rst_fill", {27'd0, a_fill}, {27'd0, r_fill}, 32'd0);
    chk2("rst_wfill", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd0);
    chk2("rst_afull_lvl0", {31'd0, a_afull}, {31'd0, r_afull}, 32'd1);
    chk2("rst_ovf", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd0);
    chk2("rst_drop", {31'd0, a_drop}, {31'd0, r_drop}, 32'd0);
    chk("reg_rst_data", {24'd0, r_data}, 32'd0);
    reset_n = 1'b1; afull_level = 5'd12;

    // Basic packet: three words, commit, read back
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk2("t1_wfill", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd3);
    chk2("t1_fill_pre", {27'd0, a_fill}, {27'd0, r_fill}, 32'd0);
    chk2("t1_empty_pre", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk2("t1_fill_post", {27'd0, a_fill}, {27'd0, r_fill}, 32'd3);
    chk("async_empty_lat1", {31'd0, a_empty}, 32'd0);
    chk("reg_empty_lat1", {31'd0, r_empty}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reg_empty_lat2", {31'd0, r_empty}, 32'd0);
    chk("reg_head", {24'd0, r_data}, 32'h11);
    drain();

    // Abort discards five words; following packet reads back alone
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk2("t2_wfill_pre", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd5);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk2("t2_wfill_abort", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd0);
    chk2("t2_drop", {31'd0, a_drop}, {31'd0, r_drop}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk2("t2_empty", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
    cycle(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drain();

    // Almost-full, full, overflow, then commit converted to drop
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      if (i == 11) chk2("t3_afull_11", {31'd0, a_afull}, {31'd0, r_afull}, 32'd0);
      if (i == 12) begin
        chk2("t3_afull_12", {31'd0, a_afull}, {31'd0, r_afull}, 32'd1);
        chk2("t3_full_12", {31'd0, a_full}, {31'd0, r_full}, 32'd0);
      end
      if (i == 16) begin
        chk2("t3_full_16", {31'd0, a_full}, {31'd0, r_full}, 32'd1);
        chk2("t3_ovf_16", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd0);
      end
    end
    chk2("t3_ovf_17", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd1);
    chk2("t3_wfill_17", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd16);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk2("t3_drop", {31'd0, a_drop}, {31'd0, r_drop}, 32'd1);
    chk2("t3_wfill_drop", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd0);
    chk2("t3_fill_drop", {27'd0, a_fill}, {27'd0, r_fill}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk2("t3_drop_pulse", {31'd0, a_drop}, {31'd0, r_drop}, 32'd0);
    chk2("t3_ovf_sticky", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd1);
    clr_err = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    chk2("t3_ovf_clr", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd0);
    drain();

    // Packet A committed, packet B written while A drains, B crosses the wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b1);
    chk2("t4_a_consumed", qa.size(), qr.size(), 32'd0);
    chk2("t4_empty_b_open", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
    chk2("t4_fill_b_open", {27'd0, a_fill}, {27'd0, r_fill}, 32'd0);
    chk2("t4_wfill_b_open", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd10);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk2("t4_fill_b", {27'd0, a_fill}, {27'd0, r_fill}, 32'd10);
    drain();

    // Reset mid-packet: three committed, two open
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
    chk2("t5_fill_pre", {27'd0, a_fill}, {27'd0, r_fill}, 32'd3);
    reset_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    qa.delete(); qr.delete(); pend.delete(); m_err = 1'b0;
    chk2("t5_fill", {27'd0, a_fill}, {27'd0, r_fill}, 32'd0);
    chk2("t5_wfill", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd0);
    chk2("t5_empty", {31'd0, a_empty}, {31'd0, r_empty}, 32'd1);
    chk2("t5_ovf", {31'd0, a_ovf}, {31'd0, r_ovf}, 32'd0);

    // Same-cycle write+commit keeps the word; write+commit+abort reverts
    cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE2, 1'b1, 1'b0, 1'b0);
    chk2("t6_fill_wc", {27'd0, a_fill}, {27'd0, r_fill}, 32'd3);
    chk2("t6_wfill_wc", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd3);
    cycle(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hF1, 1'b1, 1'b1, 1'b0);
    chk2("t6_wfill_wca", {27'd0, a_wfill}, {27'd0, r_wfill}, 32'd3);
    chk2("t6_drop_wca", {31'd0, a_drop}, {31'd0, r_drop}, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
